// File: rtl/reg_file.sv
// Architectural register file with rename tags for a ROB-based out-of-order core.
// Operand lookup is combinational. It bypasses same-cycle commits and ROB-ready results.
module reg_file #(
  parameter int ROB_WIDTH_BIT = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_flag,
  input  logic [4:0]               write_reg_id,
  input  logic [31:0]              write_val,
  input  logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  input  logic [4:0]               new_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic [4:0]               rs1_reg,
  input  logic [4:0]               rs2_reg,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic                     rs1_has_dep,
  output logic                     rs2_has_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs2_dep,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
  input  logic                     rob_rs1_ready,
  input  logic                     rob_rs2_ready,
  input  logic [31:0]              rob_rs1_val,
  input  logic [31:0]              rob_rs2_val
);

  typedef struct packed {
    logic                     has_dep;
    logic [ROB_WIDTH_BIT-1:0] dep;
    logic [31:0]              val;
  } lookup_t;

  logic [31:0]              value_q [32];
  logic [ROB_WIDTH_BIT-1:0] tag_q   [32];
  logic [31:0]              busy_q;

  // Entry 0 is never written, so x0 stays at value 0, not busy, tag 0.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 1; i < 32; i++) begin
        if (write_reg_id == 5'(i))
          value_q[i] <= write_val;
        if (clear_flag) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end else if (new_reg_id == 5'(i)) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= new_ROB_id;
        end else if (write_reg_id == 5'(i) && tag_q[i] == write_ROB_id) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Priority: x0, then stored value, then commit bypass, then ROB forward.
  function automatic lookup_t lookup(
    input logic [4:0]               rs,
    input logic                     busy,
    input logic [ROB_WIDTH_BIT-1:0] tag,
    input logic [31:0]              val,
    input logic                     commit_hit,
    input logic [31:0]              commit_val,
    input logic                     rob_ready,
    input logic [31:0]              rob_val
  );
    lookup_t r;
    r = '0;
    if (rs == 5'd0) begin
      r = '0;
    end else if (!busy) begin
      r.val = val;
    end else if (commit_hit) begin
      r.val = commit_val;
    end else if (rob_ready) begin
      r.val = rob_val;
    end else begin
      r.has_dep = 1'b1;
      r.dep     = tag;
    end
    return r;
  endfunction

  lookup_t lk1, lk2;
  logic    hit1, hit2;

  always_comb begin
    hit1 = (write_reg_id != 5'd0) && (write_ROB_id == tag_q[rs1_reg]);
    hit2 = (write_reg_id != 5'd0) && (write_ROB_id == tag_q[rs2_reg]);
    lk1  = lookup(rs1_reg, busy_q[rs1_reg], tag_q[rs1_reg], value_q[rs1_reg],
                  hit1, write_val, rob_rs1_ready, rob_rs1_val);
    lk2  = lookup(rs2_reg, busy_q[rs2_reg], tag_q[rs2_reg], value_q[rs2_reg],
                  hit2, write_val, rob_rs2_ready, rob_rs2_val);
    if (!rst_in) begin
      lk1 = '0;
      lk2 = '0;
    end
  end

  assign rs1_val     = lk1.val;
  assign rs1_has_dep = lk1.has_dep;
  assign rs1_dep     = lk1.dep;
  assign rs2_val     = lk2.val;
  assign rs2_has_dep = lk2.has_dep;
  assign rs2_dep     = lk2.dep;
  assign rob_rs1_id  = rst_in ? tag_q[rs1_reg] : '0;
  assign rob_rs2_id  = rst_in ? tag_q[rs2_reg] : '0;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit bypass, ROB forwarding, flush, x0, stall and async reset.
module tb_reg_file;
  localparam int RW = 5;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear_flag;
  logic [4:0]    write_reg_id;
  logic [31:0]   write_val;
  logic [RW-1:0] write_ROB_id;
  logic [4:0]    new_reg_id;
  logic [RW-1:0] new_ROB_id;
  logic [4:0]    rs1_reg, rs2_reg;
  logic [31:0]   rs1_val, rs2_val;
  logic          rs1_has_dep, rs2_has_dep;
  logic [RW-1:0] rs1_dep, rs2_dep;
  logic [RW-1:0] rob_rs1_id, rob_rs2_id;
  logic          rob_rs1_ready, rob_rs2_ready;
  logic [31:0]   rob_rs1_val, rob_rs2_val;

  int checks   = 0;
  int failures = 0;

  reg_file #(.ROB_WIDTH_BIT(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .write_reg_id(write_reg_id), .write_val(write_val), .write_ROB_id(write_ROB_id),
    .new_reg_id(new_reg_id), .new_ROB_id(new_ROB_id),
    .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_has_dep(rs1_has_dep), .rs2_has_dep(rs2_has_dep),
    .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
    .rob_rs1_id(rob_rs1_id), .rob_rs2_id(rob_rs2_id),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
    .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val)
  );

  // Clock and reset
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    rdy_in = 1'b1; clear_flag = 1'b0;
    write_reg_id = '0; write_val = '0; write_ROB_id = '0;
    new_reg_id = '0; new_ROB_id = '0;
    rs1_reg = '0; rs2_reg = '0;
    rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0;
    rob_rs1_val = '0; rob_rs2_val = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] v, input logic [RW-1:0] t);
    write_reg_id = r; write_val = v; write_ROB_id = t;
  endtask

  task automatic rename(input logic [4:0] r, input logic [RW-1:0] t);
    new_reg_id = r; new_ROB_id = t;
  endtask

  initial begin
    idle();
    rst_in = 1'b0;
    rs1_reg = 5'd5; rs2_reg = 5'd7;
    #1;
    check("reset_rs1_val", rs1_val, 0);
    check("reset_rs1_dep", {31'd0, rs1_has_dep}, 0);
    check("reset_rob_id", 32'(rob_rs1_id), 0);
    tick(); tick();
    rst_in = 1'b1;
    idle();
    tick();

    // Rename x5 -> tag 3, then see the dependency
    rename(5'd5, 5'd3);
    tick();
    idle(); rs1_reg = 5'd5; #1;
    check("dep_has", {31'd0, rs1_has_dep}, 1);
    check("dep_tag", 32'(rs1_dep), 3);
    check("dep_rob_id", 32'(rob_rs1_id), 3);
    check("dep_val", rs1_val, 0);

    // Matching commit bypasses the same cycle, then clears busy
    commit(5'd5, 32'hDEAD, 5'd3); #1;
    check("bypass_val", rs1_val, 32'hDEAD);
    check("bypass_has", {31'd0, rs1_has_dep}, 0);
    check("bypass_dep", 32'(rs1_dep), 0);
    tick();
    idle(); rs1_reg = 5'd5; rs2_reg = 5'd5;
    rob_rs2_ready = 1'b1; rob_rs2_val = 32'h99; #1;
    check("commit_val", rs1_val, 32'hDEAD);
    check("commit_nodep", {31'd0, rs1_has_dep}, 0);
    check("notbusy_ignores_rob", rs2_val, 32'hDEAD);

    // ROB forwarding, and commit bypass outranking it
    idle(); rename(5'd8, 5'd6); tick();
    idle(); rs1_reg = 5'd8; rob_rs1_ready = 1'b1; rob_rs1_val = 32'h77; #1;
    check("rob_fwd_val", rs1_val, 32'h77);
    check("rob_fwd_has", {31'd0, rs1_has_dep}, 0);
    check("rob_fwd_dep", 32'(rs1_dep), 0);
    commit(5'd8, 32'h66, 5'd6); #1;
    check("bypass_over_rob", rs1_val, 32'h66);
    tick();

    // Same-cycle rename and stale commit on x7: rename wins busy/tag
    idle(); rename(5'd7, 5'd4); commit(5'd7, 32'h11, 5'd2); tick();
    idle(); rs1_reg = 5'd7; #1;
    check("rn_cm_has", {31'd0, rs1_has_dep}, 1);
    check("rn_cm_dep", 32'(rs1_dep), 4);
    rob_rs1_ready = 1'b1; rob_rs1_val = 32'h22; #1;
    check("rn_cm_rob", rs1_val, 32'h22);
    // Tag mismatch commit writes value but leaves busy
    idle(); commit(5'd7, 32'h44, 5'd9); tick();
    idle(); rs1_reg = 5'd7; #1;
    check("mismatch_has", {31'd0, rs1_has_dep}, 1);
    check("mismatch_dep", 32'(rs1_dep), 4);
    idle(); commit(5'd7, 32'h33, 5'd4); tick();
    idle(); rs1_reg = 5'd7; #1;
    check("match_after_val", rs1_val, 32'h33);
    check("match_after_has", {31'd0, rs1_has_dep}, 0);

    // Flush clears busy, ignores rename, keeps commit value
    idle(); commit(5'd1, 32'h101, 5'd0); tick();
    idle(); rename(5'd1, 5'd1); tick();
    idle(); rename(5'd2, 5'd2); tick();
    idle(); rename(5'd3, 5'd3); tick();
    idle(); rs1_reg = 5'd1; #1;
    check("pre_flush_has", {31'd0, rs1_has_dep}, 1);
    idle(); clear_flag = 1'b1; rename(5'd4, 5'd5); commit(5'd9, 32'hABC, 5'd0); tick();
    idle(); rs1_reg = 5'd1; rs2_reg = 5'd3; #1;
    check("flush_x1_has", {31'd0, rs1_has_dep}, 0);
    check("flush_x1_val", rs1_val, 32'h101);
    check("flush_x3_has", {31'd0, rs2_has_dep}, 0);
    check("flush_x3_rob_id", 32'(rob_rs2_id), 0);
    rs1_reg = 5'd4; rs2_reg = 5'd9; #1;
    check("flush_x4_has", {31'd0, rs1_has_dep}, 0);
    check("flush_x4_rob_id", 32'(rob_rs1_id), 0);
    check("flush_commit_val", rs2_val, 32'hABC);

    // x0 stays zero; rdy_in low freezes state
    idle(); commit(5'd0, 32'h5, 5'd0); tick();
    idle(); #1;
    check("x0_val", rs1_val, 0);
    check("x0_has", {31'd0, rs1_has_dep}, 0);
    idle(); rdy_in = 1'b0; commit(5'd6, 32'h66, 5'd0); rename(5'd6, 5'd7); tick();
    idle(); rs1_reg = 5'd6; #1;
    check("stall_val", rs1_val, 0);
    check("stall_has", {31'd0, rs1_has_dep}, 0);

    // Asynchronous reset mid-cycle after a rename
    idle(); rename(5'd10, 5'd8); tick();
    idle(); rs1_reg = 5'd10; rs2_reg = 5'd5; #1;
    check("pre_rst_has", {31'd0, rs1_has_dep}, 1);
    #1 rst_in = 1'b0;
    #1;
    check("rst_has", {31'd0, rs1_has_dep}, 0);
    check("rst_rob_id", 32'(rob_rs1_id), 0);
    check("rst_x5_val", rs2_val, 0);
    check("rst_dep", 32'(rs1_dep), 0);
    #1 rst_in = 1'b1;
    #1;
    check("post_rst_x10_has", {31'd0, rs1_has_dep}, 0);
    check("post_rst_x5_val", rs2_val, 0);
    check("post_rst_rob_id", 32'(rob_rs1_id), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
